// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the two-requester memory arbiter.
`timescale 1ns/1ps
package mem_arbiter_pkg;
    localparam int         AW_DEF        = 14;
    localparam int         MAX_BURST_DEF = 4;
    localparam logic [3:0] WMASK_READ    = 4'b0000;

    typedef struct packed {
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } wr_cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_burst_sched.sv
// Grant decision for two requesters: sticky owner with a bounded burst length.
`timescale 1ns/1ps
module rr_burst_sched
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic       r_ptr;
    logic       r_owner;
    logic [3:0] r_bcnt;
    logic       w_any;
    logic       w_sel;
    logic       w_limit;

    // >= rather than == so a count saturated by a lone requester still yields
    always_comb begin
        w_any   = |i_req;
        w_limit = (r_bcnt >= 4'(MAX_BURST));
        w_sel   = i_req[1];
        if (i_req == 2'b11)
            w_sel = w_limit ? ~r_owner : r_ptr;
        o_gnt = {w_sel, ~w_sel} & {2{w_any & ~reset}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_bcnt  <= 4'd0;
        end else if (w_any) begin
            r_ptr   <= w_sel;
            r_owner <= w_sel;
            if (w_sel != r_owner)
                r_bcnt <= 4'd1;
            else if (r_bcnt != 4'hF)
                r_bcnt <= r_bcnt + 4'd1;
        end else begin
            r_bcnt <= 4'd0;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port front end for a single-port synchronous RAM with shared read data.
`timescale 1ns/1ps
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic [3:0]    r0_wmask,
    input  logic [AW-1:0] r0_addr,
    input  logic [31:0]   r0_wdata,
    input  logic          r1_req,
    input  logic [3:0]    r1_wmask,
    input  logic [AW-1:0] r1_addr,
    input  logic [31:0]   r1_wdata,
    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_rvalid,
    output logic          r1_rvalid,
    output logic [31:0]   rdata,
    output logic          m_en,
    output logic [AW-1:0] m_addr,
    output logic [3:0]    m_wmask,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    output logic [15:0]   busy_cnt
);
    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_wait;
    wr_cmd_t     w_cmd;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic [15:0] r_busy;

    assign w_req = {r1_req, r0_req};

    rr_burst_sched #(.MAX_BURST(MAX_BURST)) u_sched (
        .clk   (clk),
        .reset (reset),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    // Idle cycles present a read mask so the RAM never sees a stray write.
    always_comb begin
        w_cmd = '{wmask: WMASK_READ, wdata: r0_wdata};
        if (w_gnt[1])
            w_cmd = '{wmask: r1_wmask, wdata: r1_wdata};
        else if (w_gnt[0])
            w_cmd = '{wmask: r0_wmask, wdata: r0_wdata};
        w_wait = |(w_req & ~w_gnt);
    end

    assign r0_gnt    = w_gnt[0];
    assign r1_gnt    = w_gnt[1];
    assign m_en      = |w_gnt;
    assign m_addr    = w_gnt[1] ? r1_addr : r0_addr;
    assign m_wmask   = w_cmd.wmask;
    assign m_wdata   = w_cmd.wdata;
    assign rdata     = m_rdata;
    assign r0_rvalid = r_rvalid0;
    assign r1_rvalid = r_rvalid1;
    assign busy_cnt  = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_busy    <= 16'd0;
        end else begin
            r_rvalid0 <= w_gnt[0] && (r0_wmask == WMASK_READ);
            r_rvalid1 <= w_gnt[1] && (r1_wmask == WMASK_READ);
            if (w_wait)
                r_busy <= sat_inc16(r_busy);
        end
    end
endmodule
